// File: rtl/mio_bus_ctrl.sv
// mio_bus_ctrl: registered memory-mapped I/O bus controller.
// Decodes an address field into a one-hot slave select, runs a req/ack
// handshake with the selected slave, and bounds each access with a timeout.
// Unmapped regions and silent slaves complete with cpu_err=1 and zero data.
module mio_bus_ctrl #(
   parameter int NUM_SLAVES = 6,
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int SEL_HI     = 31,
   parameter int SEL_LO     = 28,
   parameter logic [NUM_SLAVES*(SEL_HI-SEL_LO+1)-1:0] SLV_REGION =
      {4'hc, 4'hd, 4'hf, 4'he, 4'h1, 4'h0},
   parameter int TIMEOUT    = 15
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         cpu_req,
   input  logic                         cpu_we,
   input  logic [ADDR_W-1:0]            cpu_addr,
   input  logic [DATA_W-1:0]            cpu_wdata,
   input  logic [DATA_W/8-1:0]          cpu_be,
   output logic [DATA_W-1:0]            cpu_rdata,
   output logic                         cpu_ready,
   output logic                         cpu_err,
   output logic [NUM_SLAVES-1:0]        slv_sel,
   output logic                         slv_we,
   output logic [ADDR_W-1:0]            slv_addr,
   output logic [DATA_W-1:0]            slv_wdata,
   output logic [DATA_W/8-1:0]          slv_be,
   input  logic [NUM_SLAVES*DATA_W-1:0] slv_rdata,
   input  logic [NUM_SLAVES-1:0]        slv_ack
);

   localparam int RW    = SEL_HI - SEL_LO + 1;
   localparam int BE_W  = DATA_W / 8;
   localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t                  state;
   state_t                  state_nx;
   logic [CNT_W-1:0]        cnt;
   logic [CNT_W-1:0]        cnt_nx;

   logic [NUM_SLAVES-1:0]   sel_nx;
   logic                    we_nx;
   logic [ADDR_W-1:0]       addr_nx;
   logic [DATA_W-1:0]       wdata_nx;
   logic [BE_W-1:0]         be_nx;
   logic [DATA_W-1:0]       rdata_nx;
   logic                    err_nx;
   logic                    ready_nx;

   logic                    hit;
   logic [NUM_SLAVES-1:0]   hit_sel;
   logic                    ack_sel;
   logic [DATA_W-1:0]       rdata_sel;

   // Region decode: first (lowest-index) slave whose code matches the field wins.
   always_comb begin
      hit     = 1'b0;
      hit_sel = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (!hit && (cpu_addr[SEL_HI:SEL_LO] == SLV_REGION[i*RW +: RW])) begin
            hit        = 1'b1;
            hit_sel[i] = 1'b1;
         end
      end
   end

   // Response mux: only the currently selected slave's ack and data are seen.
   always_comb begin
      ack_sel   = |(slv_ack & slv_sel);
      rdata_sel = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (slv_sel[i]) begin
            rdata_sel = rdata_sel | slv_rdata[i*DATA_W +: DATA_W];
         end
      end
   end

   // Next-state and next-output logic; every register holds unless changed.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      sel_nx   = slv_sel;
      we_nx    = slv_we;
      addr_nx  = slv_addr;
      wdata_nx = slv_wdata;
      be_nx    = slv_be;
      rdata_nx = cpu_rdata;
      err_nx   = cpu_err;
      ready_nx = 1'b0;

      case (state)
         IDLE: begin
            if (cpu_req) begin
               we_nx    = cpu_we;
               addr_nx  = cpu_addr;
               wdata_nx = cpu_wdata;
               be_nx    = cpu_be;
               if (hit) begin
                  sel_nx   = hit_sel;
                  cnt_nx   = '0;
                  state_nx = ACCESS;
               end else begin
                  rdata_nx = '0;
                  err_nx   = 1'b1;
                  ready_nx = 1'b1;
                  state_nx = RESP;
               end
            end
         end

         ACCESS: begin
            if (ack_sel) begin
               // Writes return zero so stale slave data never leaks to the CPU.
               rdata_nx = slv_we ? '0 : rdata_sel;
               err_nx   = 1'b0;
               ready_nx = 1'b1;
               sel_nx   = '0;
               state_nx = RESP;
            end else if (cnt == CNT_MAX) begin
               rdata_nx = '0;
               err_nx   = 1'b1;
               ready_nx = 1'b1;
               sel_nx   = '0;
               state_nx = RESP;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end

         RESP: begin
            state_nx = IDLE;
         end

         default: begin
            state_nx = IDLE;
            sel_nx   = '0;
         end
      endcase
   end

   // State and output registers; all outputs come straight from flops.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         slv_sel   <= '0;
         slv_we    <= 1'b0;
         slv_addr  <= '0;
         slv_wdata <= '0;
         slv_be    <= '0;
         cpu_rdata <= '0;
         cpu_err   <= 1'b0;
         cpu_ready <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         slv_sel   <= sel_nx;
         slv_we    <= we_nx;
         slv_addr  <= addr_nx;
         slv_wdata <= wdata_nx;
         slv_be    <= be_nx;
         cpu_rdata <= rdata_nx;
         cpu_err   <= err_nx;
         cpu_ready <= ready_nx;
      end
   end

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// tb_mio_bus_ctrl: randomized and directed bench for mio_bus_ctrl with a
// transaction-level reference model and a per-cycle compare process.
module tb_mio_bus_ctrl;

   localparam int NS  = 6;
   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int BW  = DW / 8;
   localparam int TMO = 15;

   // region code of slave i in the default map
   localparam int CODES [NS] = '{0, 1, 14, 15, 13, 12};
   // region fields used by random stimulus (7 and 3 are unmapped)
   localparam int PICKS [8]  = '{0, 1, 14, 15, 13, 12, 7, 3};

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cpu_req;
   logic              cpu_we;
   logic [AW-1:0]     cpu_addr;
   logic [DW-1:0]     cpu_wdata;
   logic [BW-1:0]     cpu_be;
   logic [DW-1:0]     cpu_rdata;
   logic              cpu_ready;
   logic              cpu_err;
   logic [NS-1:0]     slv_sel;
   logic              slv_we;
   logic [AW-1:0]     slv_addr;
   logic [DW-1:0]     slv_wdata;
   logic [BW-1:0]     slv_be;
   logic [NS*DW-1:0]  slv_rdata;
   logic [NS-1:0]     slv_ack;

   mio_bus_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_be    (cpu_be),
      .cpu_rdata (cpu_rdata),
      .cpu_ready (cpu_ready),
      .cpu_err   (cpu_err),
      .slv_sel   (slv_sel),
      .slv_we    (slv_we),
      .slv_addr  (slv_addr),
      .slv_wdata (slv_wdata),
      .slv_be    (slv_be),
      .slv_rdata (slv_rdata),
      .slv_ack   (slv_ack)
   );

   always #5 clk = ~clk;

   // expected outputs for one cycle; an all-zero entry means "plain idle"
   typedef struct packed {
      logic          all_zero;
      logic [NS-1:0] sel;
      logic          ready;
      logic          err;
      logic [DW-1:0] rdata;
      logic          bus;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [BW-1:0] be;
   } exp_t;

   typedef struct packed {
      int            cyc;
      int            run;
      logic [DW-1:0] rdata;
      logic          err;
   } rlog_t;

   exp_t  exp_q [int];
   rlog_t ready_log [$];
   int    cyc   = 0;
   int    run   = 0;
   int    n_cmp = 0;
   int    n_bad = 0;
   bit    done  = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %0h, required %0h", nm, cyc, act, req);
      end
   endtask

   // reference decode: lowest slave index whose code equals addr[31:28]
   function automatic int decode(input logic [AW-1:0] a);
      for (int i = 0; i < NS; i++) begin
         if (a[31:28] == 4'(CODES[i])) return i;
      end
      return -1;
   endfunction

   // Compare process: one check set per cycle against the model's table.
   always @(negedge clk) begin
      exp_t x;
      if (cyc >= 1 && !done) begin
         x = exp_q.exists(cyc) ? exp_q[cyc] : exp_t'(0);
         if (x.all_zero) begin
            chk("reset_zero", 128'({slv_sel, cpu_ready, cpu_err, cpu_rdata, slv_we,
                                    slv_addr, slv_wdata, slv_be}), 128'(0));
            run = 0;
         end else begin
            chk("slv_sel", 128'(slv_sel), 128'(x.sel));
            chk("cpu_ready", 128'(cpu_ready), 128'(x.ready));
            if (x.ready) begin
               chk("cpu_rdata", 128'(cpu_rdata), 128'(x.rdata));
               chk("cpu_err", 128'(cpu_err), 128'(x.err));
            end
            if (x.bus) begin
               chk("slv_we", 128'(slv_we), 128'(x.we));
               chk("slv_addr", 128'(slv_addr), 128'(x.addr));
               chk("slv_wdata", 128'(slv_wdata), 128'(x.wdata));
               chk("slv_be", 128'(slv_be), 128'(x.be));
            end
            if (slv_sel != '0) run++;
            if (cpu_ready) begin
               ready_log.push_back('{cyc: cyc, run: run, rdata: cpu_rdata, err: cpu_err});
               run = 0;
            end
         end
      end
   end

   task automatic rand_rdata();
      for (int i = 0; i < NS; i++) slv_rdata[i*DW +: DW] = $urandom;
   endtask

   task automatic scramble();
      cpu_req   = 1'($urandom);
      cpu_we    = 1'($urandom);
      cpu_addr  = $urandom;
      cpu_wdata = $urandom;
      cpu_be    = BW'($urandom);
   endtask

   // One CPU access. Called right after a rising edge; returns at the same
   // phase in the first IDLE cycle after the response. ack_k is the ACCESS
   // cycle (1-based) in which the target acks; outside 1..TMO+1 means never.
   task automatic run_txn(input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [BW-1:0] be,
                          input int ack_k, input logic [DW-1:0] data,
                          input logic [NS-1:0] spur, output int e_out);
      int            e;
      int            tgt;
      int            len;
      bit            tmo;
      logic [NS-1:0] m;
      exp_t          x;
      e   = cyc + 1;
      tgt = decode(addr);
      m   = '0;
      len = 0;
      if (tgt < 0) begin
         x = '0; x.ready = 1'b1; x.err = 1'b1; x.rdata = '0;
         exp_q[e] = x;
      end else begin
         m   = NS'(1) << tgt;
         tmo = !(ack_k >= 1 && ack_k <= TMO + 1);
         len = tmo ? TMO + 1 : ack_k;
         for (int r = 1; r <= len; r++) begin
            x = '0; x.sel = m; x.bus = 1'b1; x.we = we;
            x.addr = addr; x.wdata = wdata; x.be = be;
            exp_q[e + r - 1] = x;
         end
         x = '0; x.ready = 1'b1; x.err = tmo;
         x.rdata = (tmo || we) ? '0 : data;
         exp_q[e + len] = x;
      end
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_be = be;
      slv_ack = NS'($urandom);
      rand_rdata();
      for (int r = 1; r <= len; r++) begin
         @(posedge clk); #1;
         scramble();
         rand_rdata();
         slv_ack = ((NS'($urandom) | spur) & ~m) | ((r == ack_k) ? m : '0);
         if (r == ack_k) slv_rdata[tgt*DW +: DW] = data;
      end
      @(posedge clk); #1;
      scramble();
      slv_ack = NS'($urandom);
      @(posedge clk); #1;
      cpu_req = 1'b0;
      e_out = e;
   endtask

   // Literal expectations for the most recent completion.
   task automatic check_last(input string nm, input int c, input int r,
                             input logic [DW-1:0] rd, input logic er);
      rlog_t l;
      if (ready_log.size() == 0) begin
         n_cmp++; n_bad++;
         $display("FAIL %s_seen: got no cpu_ready, required one at cycle %0d", nm, c);
      end else begin
         l = ready_log[$];
         chk({nm, "_cycle"}, 128'(l.cyc), 128'(c));
         chk({nm, "_sel_cycles"}, 128'(l.run), 128'(r));
         chk({nm, "_rdata"}, 128'(l.rdata), 128'(rd));
         chk({nm, "_err"}, 128'(l.err), 128'(er));
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish, required finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int   e;
      int   pick;
      int   ak;
      exp_t x;
      logic [AW-1:0] a;

      rst_n = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hf000_0000;
      cpu_wdata = '0; cpu_be = '0; slv_ack = '0; slv_rdata = '0;
      x = '0; x.all_zero = 1'b1;
      for (int c = 1; c <= 3; c++) exp_q[c] = x;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1; cpu_req = 1'b0;

      // read slave0, immediate ack
      run_txn(1'b0, 32'h0000_0010, 32'h0, 4'hF, 1, 32'h1234_5678, '0, e);
      check_last("rd_fast", e + 1, 1, 32'h1234_5678, 1'b0);

      // write slave5, ack after 3 wait cycles, slave2 acks spuriously
      run_txn(1'b1, 32'hc000_0004, 32'hA5A5_A5A5, 4'hF, 4, 32'hDEAD_0001, 6'b000100, e);
      check_last("wr_wait", e + 4, 4, 32'h0, 1'b0);

      // unmapped region
      run_txn(1'b0, 32'h7000_0000, 32'h0, 4'hF, 1, 32'h5555_5555, '0, e);
      check_last("unmapped", e, 0, 32'h0, 1'b1);

      // timeout with no ack
      run_txn(1'b0, 32'hd000_0000, 32'h0, 4'hF, 0, 32'h0, '0, e);
      check_last("timeout", e + 16, 16, 32'h0, 1'b1);

      // ack exactly when the counter equals TIMEOUT
      run_txn(1'b0, 32'hd000_0000, 32'h0, 4'hF, 16, 32'hCAFE_F00D, '0, e);
      check_last("late_ack", e + 16, 16, 32'hCAFE_F00D, 1'b0);

      // reset during ACCESS cycle 2
      e = cyc + 1;
      x = '0; x.sel = 6'b010000; x.bus = 1'b1; x.we = 1'b0;
      x.addr = 32'hd000_0000; x.wdata = 32'h1111_2222; x.be = 4'h3;
      exp_q[e] = x; exp_q[e + 1] = x;
      x = '0; x.all_zero = 1'b1;
      exp_q[e + 2] = x; exp_q[e + 3] = x;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hd000_0000;
      cpu_wdata = 32'h1111_2222; cpu_be = 4'h3; slv_ack = '0;
      @(posedge clk); #1;
      cpu_req = 1'b0; slv_ack = NS'($urandom) & ~6'b010000;
      @(posedge clk); #1;
      rst_n = 1'b0; slv_ack = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_txn(1'b0, 32'hf000_0000, 32'h0, 4'hF, 2, 32'h0BAD_BEEF, '0, e);
      check_last("after_rst", e + 2, 2, 32'h0BAD_BEEF, 1'b0);

      // randomized traffic, including back-to-back accesses
      for (int t = 0; t < 60; t++) begin
         pick = $urandom_range(0, 7);
         a    = {4'(PICKS[pick]), 28'($urandom)};
         ak   = ($urandom_range(0, 9) < 7) ? int'($urandom_range(1, 6))
                                           : int'($urandom_range(0, 18));
         run_txn(1'($urandom), a, $urandom, BW'($urandom), ak, $urandom, '0, e);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
            slv_ack = NS'($urandom);
         end
      end

      repeat (2) @(posedge clk);
      #1;
      done = 1'b1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
